// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S stereo serializer with one-entry sample buffer
module i2s_transmitter #(
   parameter int BCLK_HALF_PERIOD = 12,
   parameter int SAMPLE_WIDTH     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] sample_left,
   input  logic [SAMPLE_WIDTH-1:0] sample_right,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    audio_bclk,
   output logic                    audio_lrclk,
   output logic                    audio_dout,
   output logic                    frame_start,
   output logic                    underrun,
   output logic [15:0]             underrun_count
);

   localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
   localparam int SLOT_W     = $clog2(FRAME_BITS);
   localparam int DIV_W      = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_HALF_PERIOD - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_BITS - 1);
   localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SAMPLE_WIDTH - 1);

   logic [DIV_W-1:0]      div_q;
   logic                  bclk_q;
   logic                  lrclk_q;
   logic                  dout_q;
   logic [SLOT_W-1:0]     slot_q;
   logic [FRAME_BITS-1:0] sr_q;
   logic                  pend_full_q;
   logic [FRAME_BITS-1:0] pend_word_q;
   logic                  frame_start_q;
   logic                  underrun_q;
   logic [15:0]           underrun_cnt_q;

   logic div_wrap;
   logic fall_evt;
   logic load_evt;
   logic accept;

   // A fall event is the edge where bclk goes 1->0; the frame reload piggybacks on the last slot's fall.
   always_comb begin
      div_wrap = (div_q == DIV_LAST);
      fall_evt = div_wrap && bclk_q;
      load_evt = fall_evt && (slot_q == SLOT_LAST);
      accept   = sample_valid && !pend_full_q;
   end

   // Bit-clock divider: bclk flips on the edge where the counter wraps, giving an exact 50% duty cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else if (div_wrap) begin
         div_q  <= '0;
         bclk_q <= ~bclk_q;
      end else begin
         div_q  <= div_q + DIV_W'(1);
      end
   end

   // Serial engine: on each fall the MSB goes out, then either shift or reload the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q  <= SLOT_LAST;
         lrclk_q <= 1'b1;
         dout_q  <= 1'b0;
         sr_q    <= '0;
      end else if (fall_evt) begin
         slot_q <= slot_q + SLOT_W'(1);
         dout_q <= sr_q[FRAME_BITS-1];
         if (slot_q == SLOT_LAST) begin
            lrclk_q <= 1'b0;
            sr_q    <= pend_full_q ? pend_word_q : '0;
         end else begin
            sr_q <= {sr_q[FRAME_BITS-2:0], 1'b0};
            if (slot_q == SLOT_HALF) begin
               lrclk_q <= 1'b1;
            end
         end
      end
   end

   // One-entry holding buffer; an accept can only happen while empty, so it never collides with the drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full_q <= 1'b0;
         pend_word_q <= '0;
      end else begin
         if (load_evt) begin
            pend_full_q <= 1'b0;
         end
         if (accept) begin
            pend_full_q <= 1'b1;
            pend_word_q <= {sample_left, sample_right};
         end
      end
   end

   // Per-frame status pulses and the saturating underrun tally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_start_q  <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         frame_start_q <= load_evt;
         underrun_q    <= load_evt && !pend_full_q;
         if (load_evt && !pend_full_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
         end
      end
   end

   assign sample_ready   = !pend_full_q;
   assign audio_bclk     = bclk_q;
   assign audio_lrclk    = lrclk_q;
   assign audio_dout     = dout_q;
   assign frame_start    = frame_start_q;
   assign underrun       = underrun_q;
   assign underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - self-checking bench for i2s_transmitter
module tb_i2s_transmitter;

   localparam int H = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] left = '0;
   logic [15:0] right = '0;
   logic        valid = 1'b0;
   logic        ready, bclk, lrclk, dout, fs, ur;
   logic [15:0] ucnt;

   logic        rst_sat = 1'b1;
   logic [15:0] sat_left = '0;
   logic [15:0] sat_right = '0;
   logic        sat_valid = 1'b0;
   logic        sat_ready, sat_bclk, sat_lrclk, sat_dout, sat_fs, sat_ur;
   logic [15:0] sat_ucnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        valid;
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] word;
      int          urun;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   i2s_transmitter #(.BCLK_HALF_PERIOD(H), .SAMPLE_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .sample_left(left), .sample_right(right), .sample_valid(valid),
      .sample_ready(ready), .audio_bclk(bclk), .audio_lrclk(lrclk),
      .audio_dout(dout), .frame_start(fs), .underrun(ur), .underrun_count(ucnt)
   );

   i2s_transmitter #(.BCLK_HALF_PERIOD(1), .SAMPLE_WIDTH(16)) dut_sat (
      .clk(clk), .rst(rst_sat),
      .sample_left(sat_left), .sample_right(sat_right), .sample_valid(sat_valid),
      .sample_ready(sat_ready), .audio_bclk(sat_bclk), .audio_lrclk(sat_lrclk),
      .audio_dout(sat_dout), .frame_start(sat_fs), .underrun(sat_ur), .underrun_count(sat_ucnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_bclk"},  32'(bclk),  32'd0);
      check({tag, "_lrclk"}, 32'(lrclk), 32'd1);
      check({tag, "_dout"},  32'(dout),  32'd0);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      check({tag, "_fs"},    32'(fs),    32'd0);
      check({tag, "_ur"},    32'(ur),    32'd0);
      check({tag, "_cnt"},   32'(ucnt),  32'd0);
   endtask

   // Leaves the caller at the negedge that starts cycle 0 after release.
   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      repeat (3) begin
         #1;
         check_reset_state("rst_hold");
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   initial begin
      int          fs_n, ur_n, bad, acc_n, win_ur, win_fs, low_cnt;
      logic [31:0] cap;
      logic [31:0] m_cur, m_prev, m_pword;
      bit          m_pend, e_fs, e_ur, acc;
      int          m_cnt, n, f, p, prob;
      logic        e_dout, e_acc;

      vecs[0] = '{1'b1, 16'hA5C3, 16'h0F81, 32'hA5C30F81, 0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h8000, 32'hFFFF8000, 0};
      vecs[2] = '{1'b1, 16'h0000, 16'h0001, 32'h00000001, 0};
      vecs[3] = '{1'b0, 16'h1234, 16'h5678, 32'h00000000, 1};

      // bclk timing, first fall and first load after release
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         #1;
         if (c == 0) check_reset_state("rel_c0");
         check($sformatf("bclk_c%0d", c), 32'(bclk), (c == 2 || c == 3) ? 32'd1 : 32'd0);
         check($sformatf("fs_c%0d", c), 32'(fs), (c == 4) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // table: one pair (or none) offered before the first fall, one frame captured
      for (int v = 0; v < 4; v++) begin
         do_reset();
         valid = vecs[v].valid;
         left  = vecs[v].l;
         right = vecs[v].r;
         fs_n  = 0;
         ur_n  = 0;
         cap   = '0;
         for (int c = 0; c <= 132; c++) begin
            #1;
            if (c == 0) check($sformatf("v%0d_ready0", v), 32'(ready), 32'd1);
            if (c > 0 && c < 132) begin
               fs_n += int'(fs);
               ur_n += int'(ur);
            end
            if (c > 0 && (c % (2 * H)) == 0) begin
               int j;
               j = c / (2 * H);
               if (j == 1) begin
                  check($sformatf("v%0d_first_bit", v), 32'(dout), 32'd0);
                  check($sformatf("v%0d_lr_left", v), 32'(lrclk), 32'd0);
               end else begin
                  cap[32 - (j - 1)] = dout;
               end
               if (j == 17) check($sformatf("v%0d_lr_right", v), 32'(lrclk), 32'd1);
            end
            if (c == 131) check($sformatf("v%0d_ucnt", v), 32'(ucnt), 32'(vecs[v].urun));
            @(negedge clk);
            valid = 1'b0;
            left  = 16'($urandom);
            right = 16'($urandom);
         end
         check($sformatf("v%0d_word", v), cap, vecs[v].word);
         check($sformatf("v%0d_fs_pulses", v), 32'(fs_n), 32'd1);
         check($sformatf("v%0d_ur_pulses", v), 32'(ur_n), 32'(vecs[v].urun));
      end

      // valid held high: one accept right after each load, never an underrun
      do_reset();
      valid = 1'b1;
      bad   = 0;
      acc_n = 0;
      ur_n  = 0;
      for (int c = 0; c < 512; c++) begin
         left  = 16'($urandom);
         right = 16'($urandom);
         #1;
         e_acc = (c == 0) || (c >= 4 && ((c - 4) % 128) == 0);
         if (ready !== e_acc) bad++;
         acc_n += int'(ready);
         ur_n  += int'(ur);
         @(negedge clk);
      end
      valid = 1'b0;
      check("cont_accept_cycles_bad", 32'(bad), 32'd0);
      check("cont_accepts", 32'(acc_n), 32'd5);
      check("cont_underruns", 32'(ur_n), 32'd0);

      // reset asserted mid-frame with a pair pending
      do_reset();
      for (int c = 0; c <= 86; c++) begin
         valid = (c == 10);
         left  = 16'hBEEF;
         right = 16'hCAFE;
         #1;
         if (c == 10) check("mid_cnt_before", 32'(ucnt), 32'd1);
         if (c == 86) begin
            check("mid_ready_full", 32'(ready), 32'd0);
            check("mid_bclk_high", 32'(bclk), 32'd1);
            check("mid_lrclk_right", 32'(lrclk), 32'd1);
         end
         if (c < 86) @(negedge clk);
      end
      valid = 1'b0;
      rst   = 1'b1;
      #1;
      check_reset_state("mid_async");
      repeat (3) begin
         @(negedge clk);
         #1;
         check_reset_state("mid_hold");
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c <= 4; c++) begin
         #1;
         if (c == 3) check("mid_ur_c3", 32'(ur), 32'd0);
         if (c == 4) begin
            check("mid_ur_load", 32'(ur), 32'd1);
            check("mid_fs_load", 32'(fs), 32'd1);
            check("mid_cnt_after", 32'(ucnt), 32'd1);
         end
         @(negedge clk);
      end

      // randomized traffic against a frame-level reference model
      do_reset();
      m_cur = '0; m_prev = '0; m_pword = '0; m_pend = 0; m_cnt = 0; e_fs = 0; e_ur = 0;
      for (int c = 0; c < 3000; c++) begin
         case ((c / 500) % 3)
            0:       prob = 3;
            1:       prob = 30;
            default: prob = 90;
         endcase
         valid = ($urandom_range(0, 99) < prob);
         left  = 16'($urandom);
         right = 16'($urandom);
         #1;
         f = c / (2 * H);
         if (f == 0) begin
            e_dout = 1'b0;
         end else begin
            p = (f - 1) % 32;
            e_dout = (p == 0) ? m_prev[0] : m_cur[32 - p];
         end
         check($sformatf("rnd_bclk_c%0d", c),  32'(bclk),  32'((c / H) % 2));
         check($sformatf("rnd_lrclk_c%0d", c), 32'(lrclk), (f == 0) ? 32'd1 : (((f - 1) % 32) >= 16 ? 32'd1 : 32'd0));
         check($sformatf("rnd_dout_c%0d", c),  32'(dout),  32'(e_dout));
         check($sformatf("rnd_ready_c%0d", c), 32'(ready), 32'(!m_pend));
         check($sformatf("rnd_fs_c%0d", c),    32'(fs),    32'(e_fs));
         check($sformatf("rnd_ur_c%0d", c),    32'(ur),    32'(e_ur));
         check($sformatf("rnd_cnt_c%0d", c),   32'(ucnt),  32'(m_cnt));
         acc  = valid && !m_pend;
         n    = c + 1;
         e_fs = 0;
         e_ur = 0;
         if ((n % (2 * H)) == 0 && (((n / (2 * H)) - 1) % 32) == 0) begin
            e_fs   = 1;
            m_prev = m_cur;
            if (m_pend) begin
               m_cur = m_pword;
            end else begin
               m_cur = '0;
               e_ur  = 1;
               if (m_cnt < 65535) m_cnt++;
            end
            m_pend = 0;
         end
         if (acc) begin
            m_pend  = 1;
            m_pword = {left, right};
         end
         @(negedge clk);
      end
      valid = 1'b0;

      // saturation of the underrun tally at the fastest bclk
      @(negedge clk);
      rst_sat = 1'b0;
      win_ur  = 0;
      win_fs  = 0;
      low_cnt = 0;
      bad     = 0;
      for (int c = 0; c <= 1610; c++) begin
         #1;
         if (c == 0) begin
            check("sat_rst_bclk", 32'(sat_bclk), 32'd0);
            check("sat_rst_lrclk", 32'(sat_lrclk), 32'd1);
            check("sat_rst_cnt", 32'(sat_ucnt), 32'd0);
         end
         if (c == 2) check("sat_first_ur", 32'(sat_ur), 32'd1);
         if (c == 10) begin
            check("sat_cnt_one", 32'(sat_ucnt), 32'd1);
            dut_sat.underrun_cnt_q = 16'hFFF0;
         end
         if (c == 330) check("sat_cnt_fff5", 32'(sat_ucnt), 32'h0000FFF5);
         if (c > 330) begin
            win_ur += int'(sat_ur);
            win_fs += int'(sat_fs);
            if (sat_ucnt < 16'hFFF5) low_cnt++;
            if (sat_dout !== 1'b0 || sat_ready !== 1'b1) bad++;
         end
         if (c == 1602) check("sat_ur_at_max", 32'(sat_ur), 32'd1);
         @(negedge clk);
      end
      check("sat_cnt_final", 32'(sat_ucnt), 32'h0000FFFF);
      check("sat_ur_pulses", 32'(win_ur), 32'd20);
      check("sat_fs_pulses", 32'(win_fs), 32'd20);
      check("sat_no_wrap", 32'(low_cnt), 32'd0);
      check("sat_idle_outputs", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
